eucl_sequencer: RTL and testbench

- Clocked, synchronous instruction sequencer for the 32x8 register-file/ALU execution unit.
- Fetches 28-bit instructions {opcode[27:24], op1[23:16], op2[15:8], op3[7:0]} from a synchronous program memory.
- Decodes each instruction and drives the unit's we/re/le/addr/din/fselect strobes as one-cycle micro-ops.
- Maintains the program counter, including jump, conditional jump and halt.

---
 rtl/eucl_pkg.sv | 59 +++++
 rtl/eucl_sequencer_if.sv | 27 ++
 rtl/eucl_useq_rom.sv | 118 +++++++++++
 rtl/eucl_sequencer.sv | 156 +++++++++++++++
 tb/tb_eucl_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eucl_pkg.sv
// Purpose: shared opcodes, FSM states, ALU select codes, scratch addresses and IR field helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package eucl_pkg;

    localparam int OPC_W   = 4;
    localparam int INSTR_W = 28;
    localparam int STEP_W  = 3;   // longest sequence (ADD/SUB) runs steps 0..5

    // Opcodes; 8..14 decode as NOP.
    localparam logic [OPC_W-1:0] OP_LOAD = 4'd0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd2;
    localparam logic [OPC_W-1:0] OP_INC  = 4'd3;
    localparam logic [OPC_W-1:0] OP_CMP  = 4'd4;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'd5;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'd6;
    localparam logic [OPC_W-1:0] OP_JC   = 4'd7;
    localparam logic [OPC_W-1:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    // ALU function select codes.
    localparam logic [1:0] FSEL_ADD = 2'b00;
    localparam logic [1:0] FSEL_SUB = 2'b01;
    localparam logic [1:0] FSEL_CMP = 2'b10;
    localparam logic [1:0] FSEL_INC = 2'b11;

    // Fixed scratch registers: ALU operands A/B, ALU result, comparator inputs.
    localparam int SCR_OPA   = 0;
    localparam int SCR_OPB   = 1;
    localparam int SCR_RES   = 2;
    localparam int SCR_CMP_A = 4;
    localparam int SCR_CMP_B = 5;

    // Instruction layout: {opcode[27:24], op1[23:16], op2[15:8], op3[7:0]}.
    function automatic logic [OPC_W-1:0] ir_opcode(input logic [INSTR_W-1:0] ir);
        return ir[27:24];
    endfunction

    function automatic logic [7:0] ir_op1(input logic [INSTR_W-1:0] ir);
        return ir[23:16];
    endfunction

    function automatic logic [7:0] ir_op2(input logic [INSTR_W-1:0] ir);
        return ir[15:8];
    endfunction

    function automatic logic [7:0] ir_op3(input logic [INSTR_W-1:0] ir);
        return ir[7:0];
    endfunction

endpackage

// File: rtl/eucl_sequencer_if.sv
// Purpose: execution-unit strobe bus between the sequencer (master) and the register-file/ALU (slave).
// Latency: n/a (wires only).
// Backpressure: none; strobes are single-cycle and always accepted by the unit.
// Signals: eu_we/eu_re/eu_le one-hot-or-zero strobes, eu_addr register address,
//          eu_din immediate for le, eu_fselect ALU select, eu_flags {cmp, zero, so, carry}.
interface eucl_sequencer_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          eu_we;
    logic          eu_re;
    logic          eu_le;
    logic [AW-1:0] eu_addr;
    logic [DW-1:0] eu_din;
    logic [1:0]    eu_fselect;
    logic [3:0]    eu_flags;

    modport master (
        output eu_we, eu_re, eu_le, eu_addr, eu_din, eu_fselect,
        input  eu_flags
    );

    modport slave (
        input  eu_we, eu_re, eu_le, eu_addr, eu_din, eu_fselect,
        output eu_flags
    );
endinterface

// File: rtl/eucl_useq_rom.sv
// Purpose: micro-op table; maps (opcode, step, operands) to one cycle of execution-unit strobes.
// Latency: purely combinational.
// Backpressure: none; caller advances step every cycle and stops when last is high.
// Ports: opcode/step select the row; a1..a3 are operand register addresses, imm the LOAD immediate;
//        outputs we/re/le/addr/din, fsel_load/fsel_val (ALU select change this step), last (final step).
module eucl_useq_rom
    import eucl_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic [OPC_W-1:0]  opcode,
    input  logic [STEP_W-1:0] step,
    input  logic [AW-1:0]     a1,
    input  logic [AW-1:0]     a2,
    input  logic [AW-1:0]     a3,
    input  logic [DW-1:0]     imm,
    output logic              we,
    output logic              re,
    output logic              le,
    output logic [AW-1:0]     addr,
    output logic [DW-1:0]     din,
    output logic              fsel_load,
    output logic [1:0]        fsel_val,
    output logic              last
);

    localparam logic [AW-1:0] A_OPA   = AW'(SCR_OPA);
    localparam logic [AW-1:0] A_OPB   = AW'(SCR_OPB);
    localparam logic [AW-1:0] A_RES   = AW'(SCR_RES);
    localparam logic [AW-1:0] A_CMP_A = AW'(SCR_CMP_A);
    localparam logic [AW-1:0] A_CMP_B = AW'(SCR_CMP_B);

    always_comb begin
        we        = 1'b0;
        re        = 1'b0;
        le        = 1'b0;
        addr      = '0;
        din       = '0;
        fsel_load = 1'b0;
        fsel_val  = FSEL_ADD;
        last      = 1'b0;

        case (opcode)
            OP_LOAD: begin
                if (step == 3'd0) begin
                    le  = 1'b1;
                    din = imm;
                end else begin
                    we   = 1'b1;
                    addr = a1;
                    last = 1'b1;
                end
            end

            // Stage both operands into the ALU input registers, then read the result back.
            OP_ADD, OP_SUB: begin
                case (step)
                    3'd0: begin re = 1'b1; addr = a2;    end
                    3'd1: begin we = 1'b1; addr = A_OPA; end
                    3'd2: begin re = 1'b1; addr = a3;    end
                    3'd3: begin we = 1'b1; addr = A_OPB; end
                    3'd4: begin
                        re        = 1'b1;
                        addr      = A_RES;
                        fsel_load = 1'b1;
                        fsel_val  = (opcode == OP_SUB) ? FSEL_SUB : FSEL_ADD;
                    end
                    default: begin we = 1'b1; addr = a1; last = 1'b1; end
                endcase
            end

            OP_INC: begin
                case (step)
                    3'd0: begin re = 1'b1; addr = a1;    end
                    3'd1: begin we = 1'b1; addr = A_OPA; end
                    3'd2: begin
                        re        = 1'b1;
                        addr      = A_RES;
                        fsel_load = 1'b1;
                        fsel_val  = FSEL_INC;
                    end
                    default: begin we = 1'b1; addr = a1; last = 1'b1; end
                endcase
            end

            // Final step only switches the ALU to compare; the cmp flag is then live for a later JC.
            OP_CMP: begin
                case (step)
                    3'd0: begin re = 1'b1; addr = a2;      end
                    3'd1: begin we = 1'b1; addr = A_CMP_A; end
                    3'd2: begin re = 1'b1; addr = a3;      end
                    3'd3: begin we = 1'b1; addr = A_CMP_B; end
                    default: begin
                        fsel_load = 1'b1;
                        fsel_val  = FSEL_CMP;
                        last      = 1'b1;
                    end
                endcase
            end

            OP_MOV: begin
                if (step == 3'd0) begin
                    re   = 1'b1;
                    addr = a1;
                end else begin
                    we   = 1'b1;
                    addr = a2;
                    last = 1'b1;
                end
            end

            // JMP, JC, HALT and NOP: single silent step; PC handling lives in the sequencer.
            default: last = 1'b1;
        endcase
    end

endmodule

// File: rtl/eucl_sequencer.sv
// Purpose: fetch/decode/execute sequencer driving the 32x8 register-file/ALU unit.
// Latency: FETCH->FETCH 3..8 cycles by opcode (2 + number of micro-op steps).
// Backpressure: pm_load holds the sequencer in FETCH; an instruction already past FETCH always finishes.
// Ports: clk/rst (sync, active high); start/start_pc launch from IDLE or HALT; imem_addr/imem_data
//        synchronous program memory; eu bus (master); pc, busy, halted, retired status.
module eucl_sequencer
    import eucl_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DW    = 8,
    parameter int IW    = 28,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    start_pc,
    input  logic             pm_load,
    output logic [AW-1:0]    imem_addr,
    input  logic [IW-1:0]    imem_data,
    eucl_sequencer_if.master eu,
    output logic [AW-1:0]    pc,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t            state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [IW-1:0]     ir_q;
    logic [STEP_W-1:0] step_q;
    logic [1:0]        fsel_q;
    logic [CNT_W-1:0]  retired_q;

    logic              capture_ir;
    logic              retire;
    logic              in_exec;

    logic [OPC_W-1:0]  opcode;
    logic [DW-1:0]     op1, op2, op3;
    logic [AW-1:0]     a1, a2, a3;

    logic              rom_we, rom_re, rom_le;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_din;
    logic              rom_fsel_load;
    logic [1:0]        rom_fsel_val;
    logic              rom_last;

    // Register addresses use only the low AW bits of each operand byte.
    assign opcode = ir_opcode(ir_q);
    assign op1    = ir_op1(ir_q);
    assign op2    = ir_op2(ir_q);
    assign op3    = ir_op3(ir_q);
    assign a1     = op1[AW-1:0];
    assign a2     = op2[AW-1:0];
    assign a3     = op3[AW-1:0];

    logic unused_ok;
    assign unused_ok = ^{op1[DW-1:AW], op3[DW-1:AW], eu.eu_flags[2:0]};

    eucl_useq_rom #(
        .AW (AW),
        .DW (DW)
    ) u_rom (
        .opcode    (opcode),
        .step      (step_q),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .imm       (op2),
        .we        (rom_we),
        .re        (rom_re),
        .le        (rom_le),
        .addr      (rom_addr),
        .din       (rom_din),
        .fsel_load (rom_fsel_load),
        .fsel_val  (rom_fsel_val),
        .last      (rom_last)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        capture_ir = 1'b0;
        retire     = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = start_pc;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!pm_load) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                capture_ir = 1'b1;
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                if (rom_last) begin
                    retire = 1'b1;
                    case (opcode)
                        OP_JMP:  pc_d = a1;
                        OP_JC:   pc_d = eu.eu_flags[3] ? a1 : pc_q + AW'(1);
                        OP_HALT: pc_d = pc_q;
                        default: pc_d = pc_q + AW'(1);
                    endcase
                    state_d = (opcode == OP_HALT) ? ST_HALT : ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            step_q    <= '0;
            fsel_q    <= FSEL_ADD;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture_ir) begin
                ir_q   <= imem_data;
                step_q <= '0;
            end else if (in_exec && !rom_last) begin
                step_q <= step_q + STEP_W'(1);
            end
            if (in_exec && rom_fsel_load) fsel_q <= rom_fsel_val;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Outputs depend only on registered state/step/IR. The ALU select bypasses its register
    // during the step that changes it so the new function lines up with that step's re strobe.
    assign in_exec       = (state_q == ST_EXEC);
    assign eu.eu_we      = in_exec & rom_we;
    assign eu.eu_re      = in_exec & rom_re;
    assign eu.eu_le      = in_exec & rom_le;
    assign eu.eu_addr    = in_exec ? rom_addr : '0;
    assign eu.eu_din     = in_exec ? rom_din  : '0;
    assign eu.eu_fselect = (in_exec && rom_fsel_load) ? rom_fsel_val : fsel_q;

    assign imem_addr = (state_q == ST_FETCH) ? pc_q : '0;
    assign pc        = pc_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted    = (state_q == ST_HALT);
    assign retired   = retired_q;

endmodule

// File: tb/tb_eucl_sequencer.sv
// Purpose: randomized self-checking bench for eucl_sequencer against an instruction-level model.
// Latency: checks every cycle from FETCH through EXEC to the next FETCH.
// Backpressure: exercises pm_load stalls in FETCH and pm_load raised mid-instruction.
module tb_eucl_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  start_pc;
    logic        pm_load;
    logic [4:0]  imem_addr;
    logic [27:0] imem_data;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    logic [27:0] mem [32];

    int n_chk  = 0;
    int n_fail = 0;

    eucl_sequencer_if #(.AW(5), .DW(8)) eu_bus ();

    eucl_sequencer #(
        .AW    (5),
        .DW    (8),
        .IW    (28),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_pc  (start_pc),
        .pm_load   (pm_load),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .eu        (eu_bus),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data one cycle after address.
    always @(posedge clk) imem_data <= mem[imem_addr];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       we;
        logic       re;
        logic       le;
        logic [4:0] addr;
        logic [7:0] din;
        logic [1:0] fsel;
    } uop_t;

    uop_t        seq[$];
    logic [4:0]  m_pc;
    logic [15:0] m_ret;
    logic [1:0]  m_fsel;
    bit          m_halted;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_uop(input logic we, input logic re, input logic le,
                            input logic [4:0] a, input logic [7:0] d);
        uop_t u;
        u.we = we; u.re = re; u.le = le; u.addr = a; u.din = d; u.fsel = m_fsel;
        seq.push_back(u);
    endtask

    // Expected per-cycle strobes of one instruction, straight from the micro-op table.
    task automatic build_seq(input logic [27:0] ins);
        logic [3:0] op;
        logic [7:0] b1, b2, b3;
        logic [4:0] o1, o2, o3;
        op = ins[27:24];
        b1 = ins[23:16]; b2 = ins[15:8]; b3 = ins[7:0];
        o1 = b1[4:0]; o2 = b2[4:0]; o3 = b3[4:0];
        seq.delete();
        case (op)
            4'd0: begin push_uop(0,0,1,5'd0,b2); push_uop(1,0,0,o1,8'd0); end
            4'd1, 4'd2: begin
                push_uop(0,1,0,o2,0); push_uop(1,0,0,5'd0,0);
                push_uop(0,1,0,o3,0); push_uop(1,0,0,5'd1,0);
                m_fsel = (op == 4'd1) ? 2'b00 : 2'b01;
                push_uop(0,1,0,5'd2,0); push_uop(1,0,0,o1,0);
            end
            4'd3: begin
                push_uop(0,1,0,o1,0); push_uop(1,0,0,5'd0,0);
                m_fsel = 2'b11;
                push_uop(0,1,0,5'd2,0); push_uop(1,0,0,o1,0);
            end
            4'd4: begin
                push_uop(0,1,0,o2,0); push_uop(1,0,0,5'd4,0);
                push_uop(0,1,0,o3,0); push_uop(1,0,0,5'd5,0);
                m_fsel = 2'b10;
                push_uop(0,0,0,5'd0,0);
            end
            4'd5: begin push_uop(0,1,0,o1,0); push_uop(1,0,0,o2,0); end
            default: push_uop(0,0,0,5'd0,0);
        endcase
    endtask

    task automatic do_start(input logic [4:0] p);
        start    = 1'b1;
        start_pc = p;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_fetch_addr", imem_addr, p);
        chk("start_busy", busy, 1);
        m_pc     = p;
        m_halted = 0;
    endtask

    // Called with the DUT in FETCH (sampled); runs one instruction end to end.
    task automatic exec_one(input logic [27:0] ins, input logic [3:0] flg, input bit raise_pm,
                            input int hold, input int abort_step);
        logic [3:0] op;
        logic [4:0] tgt;
        int n;
        op  = ins[27:24];
        tgt = ins[20:16];
        mem[m_pc] = ins;
        chk("fetch_addr", imem_addr, m_pc);
        pm_load = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("stall_addr", imem_addr, m_pc);
            chk("stall_strobe", {eu_bus.eu_we, eu_bus.eu_re, eu_bus.eu_le}, 0);
        end
        pm_load = 1'b0;
        @(posedge clk); #1;
        chk("dec_strobe", {eu_bus.eu_we, eu_bus.eu_re, eu_bus.eu_le}, 0);
        chk("dec_fsel", eu_bus.eu_fselect, m_fsel);
        eu_bus.eu_flags = flg;
        build_seq(ins);
        n = seq.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("uop_strobe", {eu_bus.eu_we, eu_bus.eu_re, eu_bus.eu_le},
                {seq[i].we, seq[i].re, seq[i].le});
            chk("uop_bus", {eu_bus.eu_addr, eu_bus.eu_din, eu_bus.eu_fselect},
                {seq[i].addr, seq[i].din, seq[i].fsel});
            if (i == abort_step) begin
                start = 1'b0;
                rst   = 1'b1;
                @(posedge clk); #1;
                chk("rst_strobe", {eu_bus.eu_we, eu_bus.eu_re, eu_bus.eu_le}, 0);
                chk("rst_bus", {eu_bus.eu_addr, eu_bus.eu_din, eu_bus.eu_fselect}, 0);
                chk("rst_status", {imem_addr, pc, busy, halted}, 0);
                chk("rst_retired", retired, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                m_pc = 0; m_ret = 0; m_fsel = 0; m_halted = 0;
                return;
            end
            if (raise_pm && i == 0) pm_load = 1'b1;
            // Start pulses while busy must be ignored.
            start    = ($urandom_range(0, 3) == 0);
            start_pc = 5'($urandom);
        end
        start = 1'b0;
        case (op)
            4'd6:    m_pc = tgt;
            4'd7:    m_pc = flg[3] ? tgt : m_pc + 5'd1;
            4'd15:   m_pc = m_pc;
            default: m_pc = m_pc + 5'd1;
        endcase
        m_ret++;
        @(posedge clk); #1;
        chk("next_pc", pc, m_pc);
        chk("retired", retired, m_ret);
        if (op == 4'd15) begin
            m_halted = 1;
            for (int i = 0; i < 2; i++) begin
                chk("halt_status", {halted, busy, imem_addr}, {1'b1, 1'b0, 5'd0});
                @(posedge clk); #1;
            end
        end else begin
            chk("refetch", {busy, halted, imem_addr}, {1'b1, 1'b0, m_pc});
        end
    endtask

    initial begin
        logic [27:0] ins;
        logic [3:0]  op;
        for (int i = 0; i < 32; i++) mem[i] = 28'h0;
        rst = 1'b1; start = 1'b0; start_pc = 5'd0; pm_load = 1'b0;
        eu_bus.eu_flags = 4'd0;
        m_pc = 0; m_ret = 0; m_fsel = 0; m_halted = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobe", {eu_bus.eu_we, eu_bus.eu_re, eu_bus.eu_le}, 0);
        chk("reset_bus", {eu_bus.eu_addr, eu_bus.eu_din, eu_bus.eu_fselect}, 0);
        chk("reset_status", {imem_addr, pc, busy, halted}, 0);
        chk("reset_retired", retired, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold", {busy, halted, imem_addr}, 0);

        do_start(5'd0);
        exec_one(28'h0052A00, 4'h0, 0, 0, -1);     // LOAD r5 <- 0x2A
        exec_one(28'h1070605, 4'h0, 1, 0, -1);     // ADD r7 = r6 + r5, pm_load raised mid-way
        exec_one(28'h4030201, 4'h0, 0, 3, -1);     // stalled fetch, then CMP r2, r1
        exec_one(28'h7140000, 4'b1000, 0, 0, -1);  // JC taken -> 0x14
        exec_one(28'h7140000, 4'b0000, 0, 0, -1);  // JC not taken -> 0x15
        exec_one(28'h61F0000, 4'h0, 0, 0, -1);     // JMP 31
        exec_one(28'h8000000, 4'h0, 0, 0, -1);     // NOP at 31 wraps to 0
        exec_one(28'hF000000, 4'h0, 0, 0, -1);     // HALT
        do_start(5'd3);
        exec_one(28'h3E90000, 4'h0, 0, 0, -1);     // INC, upper operand bits ignored
        exec_one(28'h2010203, 4'h0, 0, 1, -1);     // SUB
        exec_one(28'h5020300, 4'h0, 0, 0, -1);     // MOV

        for (int k = 0; k < 150; k++) begin
            op  = 4'($urandom_range(0, 15));
            ins = {op, 24'($urandom)};
            exec_one(ins, 4'($urandom), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, -1);
            if (m_halted) do_start(5'($urandom));
        end

        exec_one(28'h1070605, 4'h0, 0, 0, 3);      // reset during ADD step 3
        do_start(5'd0);
        exec_one(28'h0031100, 4'h0, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
